rrat: RTL and testbench
=======================

Name: rrat

Overview:
- Retirement register alias table for the 2-thread, 2-wide out-of-order core. It is the commit-side counterpart of the rename RAT.
- Takes up to two retiring instructions per cycle from the ROB and records the committed ARN->PRN mapping per thread.
- Returns each superseded PRN to the free list.
- On a committed mispredicted branch, pulses the per-thread mispredict signal and supplies RRAT_arr so the RAT can restore its state.

Parameters:
AR_SIZE, 32, architectural registers per thread
PR_SIZE, 64, physical registers; PRN PR_SIZE-1 is the null/unmapped PRN
ZERO_REG, 31, architectural zero register; never mapped
AR_BITS, $clog2(AR_SIZE), ARN width
PR_BITS, $clog2(PR_SIZE), PRN width

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset
commit_valid  in  2  per-slot retire valid; slot 0 is older
commit_thread_id  in  2  thread of each slot
commit_ARN_dest  in  2*AR_BITS  destination ARN per slot
commit_PRN_dest  in  2*PR_BITS  PRN allocated to that dest at rename
commit_mispredict  in  2  slot is a mispredicted branch
RRAT_arr  out  2*AR_SIZE*PR_BITS  registered committed map, [thread][ARN]
mispredict_thread_0  out  1  one-cycle recovery pulse, thread 0
mispredict_thread_1  out  1  one-cycle recovery pulse, thread 1
freed_valid  out  2  freed PRN valid per slot
freed_PRN  out  2*PR_BITS  PRN returned to free list per slot

Behaviour:
- Reset (reset==0 at posedge):
  - All RRAT entries, both threads, set to PR_SIZE-1.
  - freed_valid=0, freed_PRN=PR_SIZE-1.
  - mispredict_thread_0/1=0.
  - Inputs sampled in the reset cycle are discarded.
  - Reset mid-stream drops pending frees and pulses; no output change is visible after the reset edge.
- Commit, per slot s with commit_valid[s]=1:
  - If ARN_dest==ZERO_REG: no table write, freed_valid[s]=0.
  - Otherwise, old = current mapping of [thread][ARN], taken after any same-cycle older-slot write.
  - Table entry is written with commit_PRN_dest.
  - freed_PRN[s]=old; freed_valid[s]=1 unless old==PR_SIZE-1.
- Same-cycle, same thread, same ARN:
  - Final entry = slot 1 PRN.
  - freed_PRN[0] = prior table value.
  - freed_PRN[1] = slot 0 PRN.
- Different threads never interact, even when the ARN is the same.
- Squash: if slot 0 commit_mispredict=1 and slot 1 is the same thread, slot 1 is ignored (no write, no free). A slot 1 of the other thread commits normally.
- A mispredicting branch still commits its own dest (if any) before recovery.
- Latency: table write, freed_*, and mispredict pulses are all registered and appear exactly 1 cycle after the commit edge.
  - In the pulse cycle, RRAT_arr already includes the branch bundle's committed writes, with the squashed slot excluded.
- mispredict_thread_t is high for exactly one cycle per mispredicting commit. Both threads may pulse in the same cycle (slot 0 thread 0, slot 1 thread 1).
- RRAT_arr is a direct view of table registers; no combinational path from the commit inputs.
- freed_valid is 0 in any cycle with no qualifying commit. freed_PRN is don't-care when its valid is 0.
- Implementation: two register arrays AR_SIZE x PR_BITS, slot-0-to-slot-1 forwarding for old-PRN lookup, output flops.

Test Plan:
1. Reset: drive reset=0 for 1 cycle, then 1 -> every RRAT_arr entry =63, freed_valid=00, both mispredict outputs 0.
2. Single commit: slot0 T0 ARN4 PRN9 -> next cycle RRAT_arr[0][4]=9, freed_valid=00 (old=63). Then commit slot0 T0 ARN4 PRN12 -> RRAT_arr[0][4]=12, freed_valid[0]=1, freed_PRN[0]=9.
3. Same-ARN pair: T0 ARN4 already =12; slot0 T0 ARN4 PRN20, slot1 T0 ARN4 PRN21 -> RRAT_arr[0][4]=21, freed_PRN[0]=12 valid, freed_PRN[1]=20 valid.
4. Cross-thread isolation: slot0 T0 ARN4 PRN9, slot1 T1 ARN4 PRN10 -> RRAT_arr[0][4]=9, RRAT_arr[1][4]=10, RRAT_arr[1][5]=63, no frees.
5. Mispredict squash: slot0 T0 ARN3 PRN30 mispredict=1, slot1 T0 ARN5 PRN31 -> next cycle mispredict_thread_0=1 for 1 cycle, RRAT_arr[0][3]=30, RRAT_arr[0][5] unchanged, freed_valid[1]=0. Repeat with slot1 as T1 -> RRAT_arr[1][5]=31.
6. ZERO_REG and reset mid-op: commit ARN31 PRN40 -> no table change, no free. Commit T0 ARN2 PRN7 with reset=0 in the same cycle -> next cycle RRAT_arr[0][2]=63, freed_valid=00.

Source files
------------

// File: rtl/rrat_if.sv
// Commit bundle from the ROB to the retirement RAT: two retire slots per cycle,
// slot 0 older.
interface rrat_if #(
    parameter int unsigned AR_BITS = 5,
    parameter int unsigned PR_BITS = 6
);
    logic [1:0]              commit_valid;
    logic [1:0]              commit_thread_id;
    logic [1:0][AR_BITS-1:0] commit_ARN_dest;
    logic [1:0][PR_BITS-1:0] commit_PRN_dest;
    logic [1:0]              commit_mispredict;

    modport master (
        output commit_valid,
        output commit_thread_id,
        output commit_ARN_dest,
        output commit_PRN_dest,
        output commit_mispredict
    );

    modport slave (
        input commit_valid,
        input commit_thread_id,
        input commit_ARN_dest,
        input commit_PRN_dest,
        input commit_mispredict
    );
endinterface

// File: rtl/rrat.sv
// Retirement register alias table: committed ARN->PRN map for two threads, two
// retire slots per cycle, frees superseded PRNs and signals branch recovery.
module rrat #(
    parameter int unsigned AR_SIZE  = 32,
    parameter int unsigned PR_SIZE  = 64,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned AR_BITS  = $clog2(AR_SIZE),
    parameter int unsigned PR_BITS  = $clog2(PR_SIZE)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    rrat_if.slave                                   commit,
    output logic [1:0][AR_SIZE-1:0][PR_BITS-1:0]    RRAT_arr,
    output logic                                    mispredict_thread_0,
    output logic                                    mispredict_thread_1,
    output logic [1:0]                              freed_valid,
    output logic [1:0][PR_BITS-1:0]                 freed_PRN
);

    localparam logic [AR_BITS-1:0] ZERO_ARN = AR_BITS'(ZERO_REG);
    localparam logic [PR_BITS-1:0] NULL_PRN = PR_BITS'(PR_SIZE - 1);

    logic [1:0][AR_SIZE-1:0][PR_BITS-1:0] table_q, table_d;
    logic [1:0]                           freed_valid_q, freed_valid_d;
    logic [1:0][PR_BITS-1:0]              freed_prn_q, freed_prn_d;
    logic [1:0]                           mispredict_q, mispredict_d;

    logic [1:0]              take;
    logic [1:0]              write;
    logic                    same_dest;
    logic [1:0][PR_BITS-1:0] old_prn;

    always_comb begin
        take         = '0;
        write        = '0;
        same_dest    = 1'b0;
        old_prn      = '0;
        table_d      = table_q;
        freed_valid_d = '0;
        freed_prn_d  = {2{NULL_PRN}};
        mispredict_d = '0;

        // A mispredicting slot 0 squashes the younger slot of the same thread only.
        take[0] = commit.commit_valid[0];
        take[1] = commit.commit_valid[1] &&
                  !(commit.commit_valid[0] && commit.commit_mispredict[0] &&
                    (commit.commit_thread_id[1] == commit.commit_thread_id[0]));

        for (int s = 0; s < 2; s++) begin
            write[s] = take[s] && (commit.commit_ARN_dest[s] != ZERO_ARN);
        end

        same_dest = write[0] &&
                    (commit.commit_thread_id[1] == commit.commit_thread_id[0]) &&
                    (commit.commit_ARN_dest[1] == commit.commit_ARN_dest[0]);

        old_prn[0] = table_q[commit.commit_thread_id[0]][commit.commit_ARN_dest[0]];
        old_prn[1] = same_dest ? commit.commit_PRN_dest[0]
                               : table_q[commit.commit_thread_id[1]][commit.commit_ARN_dest[1]];

        // Slot 1 is applied last so it wins on a same-cycle collision.
        for (int s = 0; s < 2; s++) begin
            if (write[s]) begin
                table_d[commit.commit_thread_id[s]][commit.commit_ARN_dest[s]] =
                    commit.commit_PRN_dest[s];
                freed_valid_d[s] = (old_prn[s] != NULL_PRN);
                freed_prn_d[s]   = old_prn[s];
            end
            if (take[s] && commit.commit_mispredict[s]) begin
                mispredict_d[commit.commit_thread_id[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            table_q       <= {(2 * AR_SIZE){NULL_PRN}};
            freed_valid_q <= '0;
            freed_prn_q   <= {2{NULL_PRN}};
            mispredict_q  <= '0;
        end else begin
            table_q       <= table_d;
            freed_valid_q <= freed_valid_d;
            freed_prn_q   <= freed_prn_d;
            mispredict_q  <= mispredict_d;
        end
    end

    assign RRAT_arr            = table_q;
    assign freed_valid         = freed_valid_q;
    assign freed_PRN           = freed_prn_q;
    assign mispredict_thread_0 = mispredict_q[0];
    assign mispredict_thread_1 = mispredict_q[1];

endmodule

// File: tb/tb_rrat.sv
// Bench for rrat: a reference map predicts each cycle's outputs into a queue,
// a monitor compares one cycle later; directed checks cover the named scenarios.
module tb_rrat;

    localparam int unsigned AR_SIZE = 32;
    localparam int unsigned PR_SIZE = 64;
    localparam int unsigned AR_BITS = 5;
    localparam int unsigned PR_BITS = 6;
    localparam logic [PR_BITS-1:0] NULL_PRN = 6'd63;

    typedef struct {
        logic [1:0]                           fv;
        logic [1:0][PR_BITS-1:0]              fp;
        logic [1:0]                           mp;
        logic [1:0][AR_SIZE-1:0][PR_BITS-1:0] tbl;
    } exp_t;

    logic clock;
    logic reset;
    logic [1:0][AR_SIZE-1:0][PR_BITS-1:0] rrat_arr;
    logic                                 mp0, mp1;
    logic [1:0]                           freed_valid;
    logic [1:0][PR_BITS-1:0]              freed_prn;

    rrat_if #(.AR_BITS(AR_BITS), .PR_BITS(PR_BITS)) cif ();

    rrat #(
        .AR_SIZE (AR_SIZE),
        .PR_SIZE (PR_SIZE),
        .ZERO_REG(31)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .commit             (cif),
        .RRAT_arr           (rrat_arr),
        .mispredict_thread_0(mp0),
        .mispredict_thread_1(mp1),
        .freed_valid        (freed_valid),
        .freed_PRN          (freed_prn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [1:0][AR_SIZE-1:0][PR_BITS-1:0] tbl_m;
    exp_t q[$];

    // Drive one cycle of commits; the model walks slots in age order.
    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] t,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [5:0] p0, input logic [5:0] p1,
                         input logic [1:0] m);
        exp_t e;
        logic [1:0][4:0] a;
        logic [1:0][5:0] p;
        logic [5:0] old;
        a = {a1, a0};
        p = {p1, p0};
        @(negedge clock);
        e.fv = '0;
        e.fp = {2{NULL_PRN}};
        e.mp = '0;
        if (!rst) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < AR_SIZE; j++) tbl_m[i][j] = NULL_PRN;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (!v[s]) continue;
                if (s == 1 && v[0] && m[0] && t[1] == t[0]) continue;
                if (m[s]) e.mp[t[s]] = 1'b1;
                if (a[s] != 5'd31) begin
                    old = tbl_m[t[s]][a[s]];
                    tbl_m[t[s]][a[s]] = p[s];
                    e.fp[s] = old;
                    e.fv[s] = (old != NULL_PRN);
                end
            end
        end
        e.tbl = tbl_m;
        q.push_back(e);
        reset                 = rst;
        cif.commit_valid      = v;
        cif.commit_thread_id  = t;
        cif.commit_ARN_dest   = a;
        cif.commit_PRN_dest   = p;
        cif.commit_mispredict = m;
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        drive(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00);
    endtask

    exp_t mon_e;
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("freed_valid", freed_valid, mon_e.fv);
            check("mispredict_t0", mp0, mon_e.mp[0]);
            check("mispredict_t1", mp1, mon_e.mp[1]);
            for (int s = 0; s < 2; s++)
                if (mon_e.fv[s]) check($sformatf("freed_prn%0d", s), freed_prn[s], mon_e.fp[s]);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < AR_SIZE; j++)
                    check($sformatf("rrat[%0d][%0d]", i, j), rrat_arr[i][j], mon_e.tbl[i][j]);
        end
    end

    initial begin
        reset = 1'b0;
        cif.commit_valid      = '0;
        cif.commit_thread_id  = '0;
        cif.commit_ARN_dest   = '0;
        cif.commit_PRN_dest   = '0;
        cif.commit_mispredict = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < AR_SIZE; j++) tbl_m[i][j] = NULL_PRN;

        // 1. reset
        drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00);
        check("t1_arr00", rrat_arr[0][0], 63);
        check("t1_arr131", rrat_arr[1][31], 63);
        check("t1_fv", freed_valid, 0);
        check("t1_mp", {mp1, mp0}, 0);
        idle();

        // 2. single commit then overwrite
        drive(1'b1, 2'b01, 2'b00, 5'd4, 5'd0, 6'd9, 6'd0, 2'b00);
        check("t2_arr", rrat_arr[0][4], 9);
        check("t2_fv", freed_valid, 2'b00);
        drive(1'b1, 2'b01, 2'b00, 5'd4, 5'd0, 6'd12, 6'd0, 2'b00);
        check("t2b_arr", rrat_arr[0][4], 12);
        check("t2b_fv", freed_valid, 2'b01);
        check("t2b_fp", freed_prn[0], 9);

        // 3. same-ARN pair
        drive(1'b1, 2'b11, 2'b00, 5'd4, 5'd4, 6'd20, 6'd21, 2'b00);
        check("t3_arr", rrat_arr[0][4], 21);
        check("t3_fv", freed_valid, 2'b11);
        check("t3_fp0", freed_prn[0], 12);
        check("t3_fp1", freed_prn[1], 20);

        // 4. cross-thread isolation from a fresh table
        drive(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 6'd0, 6'd0, 2'b00);
        drive(1'b1, 2'b11, 2'b10, 5'd4, 5'd4, 6'd9, 6'd10, 2'b00);
        check("t4_arr04", rrat_arr[0][4], 9);
        check("t4_arr14", rrat_arr[1][4], 10);
        check("t4_arr15", rrat_arr[1][5], 63);
        check("t4_fv", freed_valid, 2'b00);

        // 5. squash of same-thread slot 1, then other-thread slot 1
        drive(1'b1, 2'b11, 2'b00, 5'd3, 5'd5, 6'd30, 6'd31, 2'b01);
        check("t5_mp0", mp0, 1);
        check("t5_mp1", mp1, 0);
        check("t5_arr03", rrat_arr[0][3], 30);
        check("t5_arr05", rrat_arr[0][5], 63);
        check("t5_fv1", freed_valid[1], 0);
        idle();
        check("t5_pulse_end", mp0, 0);
        drive(1'b1, 2'b11, 2'b10, 5'd3, 5'd5, 6'd30, 6'd31, 2'b01);
        check("t5b_arr15", rrat_arr[1][5], 31);
        check("t5b_mp0", mp0, 1);
        drive(1'b1, 2'b11, 2'b10, 5'd6, 5'd6, 6'd1, 6'd2, 2'b11);
        check("t5c_both", {mp1, mp0}, 2'b11);

        // 6. zero register and reset mid-op
        drive(1'b1, 2'b01, 2'b00, 5'd31, 5'd0, 6'd40, 6'd0, 2'b00);
        check("t6_arr031", rrat_arr[0][31], 63);
        check("t6_fv", freed_valid, 0);
        drive(1'b0, 2'b01, 2'b00, 5'd2, 5'd0, 6'd7, 6'd0, 2'b00);
        check("t6b_arr02", rrat_arr[0][2], 63);
        check("t6b_arr03", rrat_arr[0][3], 63);
        check("t6b_fv", freed_valid, 0);

        // random traffic over a small ARN window to force collisions
        for (int k = 0; k < 300; k++) begin
            logic [4:0] ra0, ra1;
            logic [1:0] rm;
            ra0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rm  = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            drive($urandom_range(0, 39) != 0, 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), ra0, ra1,
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), rm);
        end
        idle();
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
